// File: rtl/lsu_dmem_ctrl_if.sv
// Bundle of the core-side request/response handshake and the word-wide
// data-memory port of the load/store controller.
interface lsu_dmem_ctrl_if;
    // Core request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Core response
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // Data memory (async read, sync word write)
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // Controller side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_addr, mem_wd
    );

    // Environment side (core plus memory)
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Multicycle RV32I load/store initiator in front of a word-only data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extracted
// and sign/zero extended. Misaligned or illegal requests return an error
// response and never touch memory.
module lsu_dmem_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    lsu_dmem_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        req_err;
    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic [31:0] merged_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // Classify an incoming request as illegal or misaligned.
    always_comb begin
        req_err = 1'b0;
        if (bus.req_we) begin
            if (bus.req_funct3 > 3'b010) req_err = 1'b1;
        end else begin
            if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                bus.req_funct3 == 3'b111) req_err = 1'b1;
        end
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) req_err = 1'b1;
        if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
    end

    // Byte lanes written by the latched store and the store data replicated onto them.
    always_comb begin
        byte_en   = 4'b1111;
        wdata_rep = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                byte_en   = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Per-lane merge: selected lanes take store data, others keep the old word.
    // A word store enables every lane, so the old word drops out entirely.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = byte_en[gi] ? wdata_rep[gi*8 +: 8]
                                                        : word_q[gi*8 +: 8];
        end
    endgenerate

    // Extract and extend load data from the word currently on mem_rd.
    always_comb begin
        load_byte = bus.mem_rd[{addr_q[1:0], 3'b000} +: 8];
        load_half = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0, load_half};
            default: load_data = bus.mem_rd;
        endcase
    end

    // Next-state and register-update logic for the request FSM.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        word_d       = word_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_err) begin
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end else if (bus.req_we && bus.req_funct3[1:0] == 2'b10) begin
                        // Full-word store needs no read of the old word.
                        resp_rdata_d = 32'h0;
                        resp_err_d   = 1'b0;
                        state_d      = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                word_d     = bus.mem_rd;
                resp_err_d = 1'b0;
                if (we_q) begin
                    resp_rdata_d = 32'h0;
                    state_d      = WRITE;
                end else begin
                    resp_rdata_d = load_data;
                    state_d      = RESP;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            word_q       <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            word_q       <= word_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Outputs decode straight from the state register, so mem_we drops
    // with reset without waiting for a clock edge.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_we     = (state_q == WRITE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wd     = merged_word;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl: the driver pushes expected responses
// and memory writes (with their cycle) into queues; a monitor pops and
// compares whenever the DUT pulses resp_valid or mem_we.
module tb_lsu_dmem_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    lsu_dmem_ctrl_if bus ();

    lsu_dmem_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;

    resp_t exp_resp[$];
    wr_t   exp_wr[$];

    // Memory model: 64 words, asynchronous read, synchronous word write.
    logic [31:0] mem [0:63];

    assign bus.mem_rd = (bus.mem_addr[31:8] == 24'h0) ? mem[bus.mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr[31:8] == 24'h0 && bus.mem_addr[1:0] == 2'b00)
            mem[bus.mem_addr[7:2]] <= bus.mem_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every response pulse and every memory write.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid === 1'b1) begin
            if (exp_resp.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_resp.pop_front();
                check("resp_cycle", cyc, e.cyc);
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
                $display("resp  cyc=%0d rdata=%h err=%b", cyc, bus.resp_rdata, bus.resp_err);
            end
        end
        if (rst_n && bus.mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("write_cycle", cyc, w.cyc);
                check("mem_addr", bus.mem_addr, w.addr);
                check("mem_wd", bus.mem_wd, w.wd);
                $display("write cyc=%0d addr=%h wd=%h", cyc, bus.mem_addr, bus.mem_wd);
            end
        end
    end

    // Drive one request, wait (bounded) for acceptance, and post expectations.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic do_wr, input int wr_lat, input logic [31:0] wr_wd,
                         output int acc);
        int n;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("accept_timeout", 32'd1, 32'd0);
            acc = -1;
        end else begin
            resp_t r;
            acc = cyc;
            r.cyc = acc + lat; r.rdata = exp_rdata; r.err = exp_err;
            exp_resp.push_back(r);
            if (do_wr) begin
                wr_t w;
                w.cyc = acc + wr_lat; w.addr = {addr[31:2], 2'b00}; w.wd = wr_wd;
                exp_wr.push_back(w);
            end
            $display("req   cyc=%0d we=%b f3=%b addr=%h wdata=%h", acc, we, f3, addr, wdata);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int a0, a1;
        int n;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'hDEADBEEF;
        mem[8]  = 32'h11223344;
        mem[12] = 32'hA5A5A5A5;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        check("rst_mem_we", {31'h0, bus.mem_we}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, bus.resp_err}, 32'd0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        rst_n = 1'b1;

        // Loads
        issue(1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 1'b0, 0, 32'h0, a0);
        idle_cycles(3);
        mem[4] = 32'h80FF7F01;
        issue(1'b0, 3'b000, 32'h13, 32'h0, 2, 32'hFFFFFF80, 1'b0, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h00000080, 1'b0, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 2, 32'hFFFF80FF, 1'b0, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 2, 32'h00007F01, 1'b0, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b000, 32'h11, 32'h0, 2, 32'h0000007F, 1'b0, 1'b0, 0, 32'h0, a0);

        // Sub-word and word stores
        issue(1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 3, 32'h0, 1'b0, 1'b1, 2, 32'h1122AA44, a0);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 2, 32'h1122AA44, 1'b0, 1'b0, 0, 32'h0, a0);
        issue(1'b1, 3'b001, 32'h06, 32'h1234BEEF, 3, 32'h0, 1'b0, 1'b1, 2, 32'hBEEF0000, a0);
        issue(1'b1, 3'b010, 32'h08, 32'hCAFEF00D, 2, 32'h0, 1'b0, 1'b1, 1, 32'hCAFEF00D, a0);
        issue(1'b0, 3'b010, 32'h08, 32'h0, 2, 32'hCAFEF00D, 1'b0, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b010, 32'h04, 32'h0, 2, 32'hBEEF0000, 1'b0, 1'b0, 0, 32'h0, a0);

        // Errors: response one cycle after accept, no memory write
        issue(1'b0, 3'b010, 32'h02, 32'h0, 1, 32'h0, 1'b1, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b001, 32'h01, 32'h0, 1, 32'h0, 1'b1, 1'b0, 0, 32'h0, a0);
        issue(1'b1, 3'b100, 32'h00, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 0, 32'h0, a0);
        issue(1'b1, 3'b010, 32'h0A, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 0, 32'h0, a0);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1'b1, 1'b0, 0, 32'h0, a0);
        issue(1'b1, 3'b001, 32'h03, 32'h0000FFFF, 1, 32'h0, 1'b1, 1'b0, 0, 32'h0, a0);

        // Flow control: valid held through a busy SB
        issue(1'b1, 3'b000, 32'h22, 32'h00000055, 3, 32'h0, 1'b0, 1'b1, 2, 32'h1155AA44, a0);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 2, 32'h1155AA44, 1'b0, 1'b0, 0, 32'h0, a1);
        check("backpressure_accept_gap", a1 - a0, 32'd4);
        idle_cycles(4);

        // Reset during WRITE
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h30;
        bus.req_wdata  = 32'h00000000;
        a0 = cyc;
        begin
            wr_t w;
            w.cyc = a0 + 2; w.addr = 32'h30; w.wd = 32'hA5A5A500;
            exp_wr.push_back(w);
        end
        $display("req   cyc=%0d we=1 f3=000 addr=00000030 wdata=00000000 (reset in WRITE)", a0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        #2;
        check("pre_rst_mem_we", {31'h0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", {31'h0, bus.mem_we}, 32'd0);
        check("midrst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        check("midrst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mem_unchanged", mem[12], 32'hA5A5A5A5);
        check("post_rst_req_ready", {31'h0, bus.req_ready}, 32'd1);

        // Drain and make sure nothing expected is still outstanding
        n = 0;
        while ((exp_resp.size() != 0 || exp_wr.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_queue_empty", exp_resp.size(), 32'd0);
        check("write_queue_empty", exp_wr.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
- Multicycle load/store initiator between the RV32I core and the word-only data memory port (async read, sync word write, word-aligned only).
- Accepts one load or store per handshake and decodes funct3.
- Performs sub-word stores (SB/SH) as read-modify-write and sub-word loads with sign or zero extension.
- Flags misaligned and illegal accesses; no memory write occurs on an error.

Parameters:
- None. Widths are fixed by RV32I: 32-bit address and data, 3-bit funct3.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal access; valid only with resp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word-aligned address: {addr_q[31:2],2'b00}.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data, combinational from mem_addr.

Behaviour:
- Reset: state = IDLE; all request latches, word register, mem_we, mem_wd, resp_valid, resp_rdata and resp_err are 0; req_ready = 1.
- FSM states: IDLE, READ, WRITE, RESP. req_ready = (state == IDLE). mem_we = (state == WRITE).
- IDLE: on req_valid && req_ready, latch we, funct3, addr and wdata, then classify:
  - Error if any of the following, and go to RESP with err = 1:
    - illegal load funct3 (011, 110, 111);
    - illegal store funct3 (any value other than 000/001/010);
    - half access with addr[0] = 1;
    - word access with addr[1:0] != 00.
  - SW goes directly to WRITE with mem_wd = wdata.
  - All loads, SB and SH go to READ.
- READ (1 cycle): mem_addr is driven; mem_rd is sampled into word_q at the closing edge.
  - Load: go to RESP with resp_rdata computed from the sampled word.
  - SB/SH: go to WRITE with the merged word.
- Load extraction, with byte index b = addr[1:0]:
  - LB/LBU: byte b, sign- or zero-extended.
  - LH/LHU: half addr[1], sign- or zero-extended.
  - LW: whole word.
- Store merge:
  - SB replaces byte b of word_q with wdata[7:0].
  - SH replaces half addr[1] with wdata[15:0].
  - All other bytes are preserved.
- WRITE (1 cycle): mem_we = 1; memory updates at the closing edge; then go to RESP.
- RESP (1 cycle): resp_valid = 1 with resp_rdata and resp_err registered; then IDLE. There is no response backpressure; the core must take the pulse.
- Latency, counted from the accept cycle as cycle 0:
  - load: resp_valid in cycle 2;
  - SW: mem_we in cycle 1, resp in cycle 2;
  - SB/SH: READ in cycle 1, WRITE in cycle 2, resp in cycle 3;
  - error: resp in cycle 1.
- req_valid while not in IDLE is ignored (req_ready = 0); request inputs are not re-sampled until IDLE.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately following RESP.
- Outside RESP: resp_valid = 0; resp_rdata and resp_err hold their last values but are don't-care.
- Reset asserted mid-operation: immediate return to IDLE; mem_we drops asynchronously; no write completes and no response is issued.

Test Plan:
- LW at 0x10 with mem word 0xDEADBEEF -> resp_valid in cycle 2, resp_rdata = 0xDEADBEEF, err = 0, mem_we never high.
- LB at 0x13 and LBU at 0x13 with word 0x80FF7F01 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SB 0xAA to 0x21 with old word 0x11223344 -> READ then WRITE with mem_wd = 0x1122AA44, resp in cycle 3; a following LW at 0x20 reads 0x1122AA44.
- SH at 0x06 with wdata 0x0000BEEF and old word 0 -> mem_wd = 0xBEEF0000; SW at 0x08 with 0xCAFEF00D -> mem_we in cycle 1, resp in cycle 2.
- Errors:
  - LW at 0x02 -> resp_err = 1 in cycle 1, no mem_we.
  - LH at 0x01 -> resp_err = 1, no mem_we.
  - Store with funct3 = 100 -> resp_err = 1, no mem_we.
- Flow control and reset:
  - req_valid held high during a busy SB -> second request is accepted only in the IDLE cycle after RESP.
  - rst_n pulsed low during WRITE -> mem_we falls immediately, memory word unchanged, no resp_valid, req_ready = 1.
